nip_window_writer: RTL and testbench

- Consumer end of the row-buffer column stream. The row-buffer top emits one K-pixel vertical column per strobe. This block takes those columns and:
  - assembles KxK windows in a shift-register array;
  - computes a saturated, scaled window sum (box filter);
  - writes each valid result pixel to the external output memory, using a sequential write address.
- It sits between the row-buffer top and the output memory model, and mirrors the external-memory read path on the write side.

---
 rtl/nip_window_writer_pkg.sv | 33 +++
 rtl/nip_window_sum.sv | 72 +++++++
 rtl/nip_window_writer.sv | 142 ++++++++++++++
 tb/tb_nip_window_writer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/nip_window_writer_pkg.sv
// Shared parameters, FSM encoding and width helpers for the window writer slice.
// Defaults describe the full-size image; benches and integrators override them per instance.
package nip_window_writer_pkg;

    localparam int K_DEF                 = 3;
    localparam int PIXEL_WIDTH_DEF       = 8;
    localparam int IMG_W_DEF             = 512;
    localparam int IMG_H_DEF             = 512;
    localparam int SHIFT_DEF             = 0;
    localparam int OMEM_W_ADDR_WIDTH_DEF = 18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Full-precision width of a K*K pixel sum.
    function automatic int sum_width(input int k, input int pw);
        return pw + $clog2(k * k);
    endfunction

    function automatic int out_pixels(input int w, input int h, input int k);
        return (w - k + 1) * (h - k + 1);
    endfunction

    // Counter width for a 0..n-1 range, never below one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nip_window_sum.sv
// Two-stage box-filter adder: stage 1 registers per-row sums, stage 2 the total, shift and saturation.
// Latency 2 cycles, one result per cycle, no backpressure; kill drops everything in flight.
module nip_window_sum
    import nip_window_writer_pkg::*;
#(
    parameter int K           = K_DEF,
    parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF,
    parameter int SHIFT       = SHIFT_DEF,
    parameter int SUM_WIDTH   = sum_width(K, PIXEL_WIDTH)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 kill,
    input  logic                                 in_vld,
    input  logic [K-1:0][K-1:0][PIXEL_WIDTH-1:0] win,
    output logic                                 stage1_vld,
    output logic                                 out_vld,
    output logic [PIXEL_WIDTH-1:0]               out_dat
);

    localparam logic [SUM_WIDTH-1:0] PIX_MAX = SUM_WIDTH'((1 << PIXEL_WIDTH) - 1);

    logic [K-1:0][SUM_WIDTH-1:0] row_sum_c;
    logic [K-1:0][SUM_WIDTH-1:0] row_sum_q;
    logic [SUM_WIDTH-1:0]        total_c;
    logic [SUM_WIDTH-1:0]        scaled_c;
    logic [PIXEL_WIDTH-1:0]      sat_c;

    // win is indexed [column][row]; each row is summed across the K columns.
    always_comb begin
        row_sum_c = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                row_sum_c[r] = row_sum_c[r] + SUM_WIDTH'(win[c][r]);
            end
        end
    end

    always_comb begin
        total_c = '0;
        for (int r = 0; r < K; r++) begin
            total_c = total_c + row_sum_q[r];
        end
        scaled_c = total_c >> SHIFT;
        sat_c    = (scaled_c > PIX_MAX) ? '1 : scaled_c[PIXEL_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage1_vld <= 1'b0;
            row_sum_q  <= '0;
        end else begin
            stage1_vld <= in_vld && !kill;
            if (in_vld) begin
                row_sum_q <= row_sum_c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld <= 1'b0;
            out_dat <= '0;
        end else begin
            out_vld <= stage1_vld && !kill;
            if (stage1_vld && !kill) begin
                out_dat <= sat_c;
            end
        end
    end

endmodule

// File: rtl/nip_window_writer.sv
// Assembles KxK windows from the column stream and writes box-filtered pixels to sequential addresses.
// Column accepted at edge t is written at edge t+2; fully pipelined, no backpressure (columns outside RUN are dropped).
module nip_window_writer
    import nip_window_writer_pkg::*;
#(
    parameter int K                 = K_DEF,
    parameter int PIXEL_WIDTH       = PIXEL_WIDTH_DEF,
    parameter int IMG_W             = IMG_W_DEF,
    parameter int IMG_H             = IMG_H_DEF,
    parameter int SHIFT             = SHIFT_DEF,
    parameter int OMEM_W_ADDR_WIDTH = OMEM_W_ADDR_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         col_valid,
    input  logic [K*PIXEL_WIDTH-1:0]     col_in,
    output logic [OMEM_W_ADDR_WIDTH-1:0] out_addr,
    output logic [PIXEL_WIDTH-1:0]       out_data,
    output logic                         out_we,
    output logic                         done
);

    localparam int SUM_WIDTH  = sum_width(K, PIXEL_WIDTH);
    localparam int OUT_PIXELS = out_pixels(IMG_W, IMG_H, K);
    localparam int XW         = cnt_width(IMG_W);
    localparam int YW         = cnt_width(IMG_H - K + 1);

    localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
    localparam logic [XW-1:0] X_FIRST = XW'(K - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - K);

    state_t state;
    state_t next_state;

    logic [XW-1:0]                        x;
    logic [YW-1:0]                        y;
    logic [K-1:0][K-1:0][PIXEL_WIDTH-1:0] win;
    logic                                 win_vld;
    logic [OMEM_W_ADDR_WIDTH-1:0]         wr_cnt;
    logic                                 accept;
    logic                                 last_col;
    logic                                 stage1_vld;

    // start wins over a same-cycle column, which is simply dropped.
    assign accept   = (state == ST_RUN) && col_valid && !start;
    assign last_col = (x == X_LAST) && (y == Y_LAST);

    always_comb begin
        next_state = state;
        if (start) begin
            next_state = ST_RUN;
        end else begin
            case (state)
                ST_IDLE:  next_state = ST_IDLE;
                ST_RUN:   if (accept && last_col) next_state = ST_FLUSH;
                // The final result is on the output this cycle once both earlier stages are empty.
                ST_FLUSH: if (!win_vld && !stage1_vld) next_state = ST_DONE;
                ST_DONE:  next_state = ST_DONE;
                default:  next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            done  <= (next_state == ST_DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x       <= '0;
            y       <= '0;
            win_vld <= 1'b0;
        end else if (start) begin
            x       <= '0;
            y       <= '0;
            win_vld <= 1'b0;
        end else if (accept) begin
            win_vld <= (x >= X_FIRST);
            if (last_col) begin
                x <= '0;
                y <= '0;
            end else if (x == X_LAST) begin
                x <= '0;
                y <= y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end else begin
            win_vld <= 1'b0;
        end
    end

    // Window contents survive row wrap; win_vld alone decides whether they form a result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win <= '0;
        end else if (accept) begin
            for (int c = 0; c < K - 1; c++) begin
                win[c] <= win[c+1];
            end
            win[K-1] <= col_in;
        end
    end

    // out_addr is loaded together with out_data so it holds the last written address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt   <= '0;
            out_addr <= '0;
        end else if (start) begin
            wr_cnt   <= '0;
            out_addr <= '0;
        end else if (stage1_vld) begin
            out_addr <= wr_cnt;
            wr_cnt   <= wr_cnt + OMEM_W_ADDR_WIDTH'(1);
        end
    end

    nip_window_sum #(
        .K           (K),
        .PIXEL_WIDTH (PIXEL_WIDTH),
        .SHIFT       (SHIFT),
        .SUM_WIDTH   (SUM_WIDTH)
    ) u_sum (
        .clk        (clk),
        .rst        (rst),
        .kill       (start),
        .in_vld     (win_vld),
        .win        (win),
        .stage1_vld (stage1_vld),
        .out_vld    (out_we),
        .out_dat    (out_data)
    );

endmodule

// File: tb/tb_nip_window_writer.sv
// Directed bench for nip_window_writer on a 5x4 image, K=3, with SHIFT=0 and SHIFT=4 instances on shared stimulus.
// Per-cycle frame tables plus hand sequences for gaps, restart-kill and asynchronous reset.
module tb_nip_window_writer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        col_valid;
    logic [23:0] col_in;
    logic [17:0] out_addr0;
    logic [17:0] out_addr4;
    logic [7:0]  out_data0;
    logic [7:0]  out_data4;
    logic        out_we0;
    logic        out_we4;
    logic        done0;
    logic        done4;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit         st;
        bit         cv;
        logic [7:0] px;
        bit         we;
        int         d0;
        int         d4;
        int         addr;
        bit         dn;
    } vec_t;

    vec_t tbl[$];

    nip_window_writer #(
        .K(3), .PIXEL_WIDTH(8), .IMG_W(5), .IMG_H(4), .SHIFT(0), .OMEM_W_ADDR_WIDTH(18)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .col_valid(col_valid), .col_in(col_in),
        .out_addr(out_addr0), .out_data(out_data0), .out_we(out_we0), .done(done0)
    );

    nip_window_writer #(
        .K(3), .PIXEL_WIDTH(8), .IMG_W(5), .IMG_H(4), .SHIFT(4), .OMEM_W_ADDR_WIDTH(18)
    ) dut_s4 (
        .clk(clk), .rst(rst), .start(start), .col_valid(col_valid), .col_in(col_in),
        .out_addr(out_addr4), .out_data(out_data4), .out_we(out_we4), .done(done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_row(input string tag, input bit we, input int d0, input int d4,
                             input int addr, input bit dn);
        chk({tag, "_we"}, int'(out_we0), int'(we));
        chk({tag, "_we_s4"}, int'(out_we4), int'(we));
        chk({tag, "_addr"}, int'(out_addr0), addr);
        chk({tag, "_addr_s4"}, int'(out_addr4), addr);
        chk({tag, "_done"}, int'(done0), int'(dn));
        chk({tag, "_done_s4"}, int'(done4), int'(dn));
        if (we) begin
            chk({tag, "_data"}, int'(out_data0), d0);
            chk({tag, "_data_s4"}, int'(out_data4), d4);
        end
    endtask

    // Called at a falling edge: drive inputs, then return at the next falling edge.
    task automatic step(input bit st, input bit cv, input logic [7:0] px);
        start     = st;
        col_valid = cv;
        col_in    = {px, px, px};
        @(negedge clk);
    endtask

    // One back-to-back frame: row 0 carries start with a column that must be dropped,
    // row 14 is a column in DONE that must be ignored.
    task automatic add_frame(input logic [7:0] px, input int d0, input int d4);
        bit [15:0] we_pat   = 16'h1CE0;
        bit [15:0] cv_pat   = 16'h47FF;
        bit [15:0] done_pat = 16'hE000;
        int        addr_pat [16] = '{0, 0, 0, 0, 0, 0, 1, 2, 2, 2, 3, 4, 5, 5, 5, 5};
        vec_t      v;
        for (int r = 0; r < 16; r++) begin
            v.st   = (r == 0);
            v.cv   = cv_pat[r];
            v.px   = px;
            v.we   = we_pat[r];
            v.d0   = d0;
            v.d4   = d4;
            v.addr = addr_pat[r];
            v.dn   = done_pat[r];
            tbl.push_back(v);
        end
    endtask

    task automatic run_table(input string tag);
        foreach (tbl[i]) begin
            step(tbl[i].st, tbl[i].cv, tbl[i].px);
            check_row($sformatf("%s_r%0d", tag, i), tbl[i].we, tbl[i].d0, tbl[i].d4,
                      tbl[i].addr, tbl[i].dn);
        end
        tbl.delete();
    endtask

    initial begin
        int wi;
        rst       = 1'b1;
        start     = 1'b0;
        col_valid = 1'b0;
        col_in    = '0;
        @(negedge clk);
        check_row("reset", 1'b0, 0, 0, 0, 1'b0);
        chk("reset_data", int'(out_data0), 0);
        rst = 1'b0;
        @(negedge clk);

        // Frames of constant pixels: 1 -> 9 (0 after >>4), 0xFF -> saturated 255 (143 after >>4).
        add_frame(8'd1, 9, 0);
        run_table("ones");
        add_frame(8'hFF, 255, 143);
        run_table("ff");

        // pixel = x, three idle cycles after each strobe; window sum = 9*x - 9.
        step(1'b1, 1'b0, 8'd0);
        check_row("gap_start", 1'b0, 0, 0, 0, 1'b0);
        wi = 0;
        for (int y = 0; y < 2; y++) begin
            for (int x = 0; x < 5; x++) begin
                for (int k = 0; k < 4; k++) begin
                    bit exp_we;
                    bit exp_dn;
                    step(1'b0, k == 0, 8'(x));
                    exp_we = (k == 2) && (x >= 2);
                    exp_dn = (y == 1) && (x == 4) && (k == 3);
                    if (exp_we) begin
                        check_row($sformatf("gap_y%0d_x%0d_k%0d", y, x, k), 1'b1,
                                  9 * x - 9, (9 * x - 9) >> 4, wi, exp_dn);
                        wi++;
                    end else begin
                        check_row($sformatf("gap_y%0d_x%0d_k%0d", y, x, k), 1'b0, 0, 0,
                                  (wi == 0) ? 0 : wi - 1, exp_dn);
                    end
                end
            end
        end

        // Three columns put a write in flight; the frame table's start row must kill it.
        step(1'b1, 1'b0, 8'd0);
        check_row("kill_start", 1'b0, 0, 0, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'd3);
            check_row($sformatf("kill_col%0d", i), 1'b0, 0, 0, 0, 1'b0);
        end
        add_frame(8'd3, 27, 1);
        run_table("restart");

        // Asynchronous reset in the middle of the first row of the second column row.
        step(1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, 8'd2);
        end
        check_row("pre_rst", 1'b1, 18, 1, 2, 1'b0);
        col_valid = 1'b0;
        rst       = 1'b1;
        #1;
        check_row("async_rst", 1'b0, 0, 0, 0, 1'b0);
        chk("async_rst_data", int'(out_data0), 0);
        chk("async_rst_data_s4", int'(out_data4), 0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'd4);
        end
        step(1'b0, 1'b0, 8'd0);
        check_row("post_rst_gap", 1'b0, 0, 0, 0, 1'b0);
        step(1'b0, 1'b0, 8'd0);
        check_row("post_rst_first", 1'b1, 36, 2, 0, 1'b0);
        step(1'b0, 1'b0, 8'd0);
        check_row("post_rst_idle", 1'b0, 0, 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
